// File: rtl/apb_master_arb.sv
// ---------------------------------------------------------------------------
// apb_master_arb
//   Round-robin arbiter in front of a single APB4 master port. Each requester
//   raises req with a fully described transfer. The arbiter picks one owner,
//   runs the APB SETUP/ACCESS handshake and returns the captured read data
//   and error status to that owner with a one-cycle done pulse.
//
//   Optional feature (compile-time macro APB_ARB_TIMEOUT_EN):
//     defined     - ACCESS is abandoned after TIMEOUT cycles without pready.
//                   The transfer completes with err=1 and rdata=0.
//     not defined - ACCESS waits for pready indefinitely.
//
// Parameters
//   NREQ        number of requesters (2..8)
//   ADDR_WIDTH  APB address width
//   DATA_WIDTH  APB data width (multiple of 8); strobe width is DATA_WIDTH/8
//   PROT        constant value driven on prot
//   TIMEOUT     ACCESS cycle limit (used only with APB_ARB_TIMEOUT_EN)
//
// Ports
//   clk        clock; all logic runs on the rising edge
//   prst       synchronous, active-high reset
//   req        per-requester request, held until the matching done
//   req_addr   packed addresses, slot i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_write  per-requester direction (1 = write)
//   req_wdata  packed write data, slot i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_strb   packed write strobes, slot i = [i*DATA_WIDTH/8 +: DATA_WIDTH/8]
//   done       one-hot, one-cycle completion pulse to the owner
//   rdata      captured read data, valid while done != 0
//   err        captured slverr (or timeout), valid while done != 0
//   paddr, prot, pwrite, psel, penable, pwdata, pstrb   APB master outputs
//   pready, slverr, prdata                              APB slave response
// ---------------------------------------------------------------------------
module apb_master_arb #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           prst,
  // requester side
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NREQ-1:0]                req_write,
  input  logic [NREQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NREQ*(DATA_WIDTH/8)-1:0] req_strb,
  output logic [NREQ-1:0]                done,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           err,
  // APB master side
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [2:0]                     prot,
  output logic                           pwrite,
  output logic                           psel,
  output logic                           penable,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic                           pready,
  input  logic                           slverr,
  input  logic [DATA_WIDTH-1:0]          prdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Unsupported configurations stop elaboration instead of building odd logic.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
    $error("apb_master_arb: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        rr_ptr, rr_nxt;
  logic [PTR_W-1:0]        owner, owner_nxt;

  logic [ADDR_WIDTH-1:0]   paddr_nxt;
  logic                    pwrite_nxt;
  logic                    psel_nxt;
  logic                    penable_nxt;
  logic [DATA_WIDTH-1:0]   pwdata_nxt;
  logic [STRB_W-1:0]       pstrb_nxt;
  logic [NREQ-1:0]         done_nxt;
  logic [DATA_WIDTH-1:0]   rdata_nxt;
  logic                    err_nxt;

  // Completion of the ACCESS phase and the response it carries back.
  logic                    fin;
  logic [DATA_WIDTH-1:0]   fin_rdata;
  logic                    fin_err;

  // Round-robin pick.
  logic [PTR_W-1:0]        grant_idx;
  logic                    grant_found;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0]        tcnt, tcnt_nxt;
`endif

  assign prot = PROT;

  // -------------------------------------------------------------------------
  // Arbitration: first requester at or after rr_ptr, wrapping modulo NREQ.
  // The modulo is explicit so non power-of-two NREQ wraps correctly.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!grant_found && req[(int'(rr_ptr) + i) % int'(NREQ)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'((int'(rr_ptr) + i) % int'(NREQ));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic.
  // NOTE: every signal gets its hold/idle value before the case statement, so
  // no path leaves a variable unassigned and no latch can be inferred.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    owner_nxt   = owner;
    paddr_nxt   = paddr;
    pwrite_nxt  = pwrite;
    pwdata_nxt  = pwdata;
    pstrb_nxt   = pstrb;
    psel_nxt    = psel;
    penable_nxt = penable;
    done_nxt    = '0;
    rdata_nxt   = rdata;
    err_nxt     = 1'b0;   // err is only meaningful alongside done
    fin         = 1'b0;
    fin_rdata   = prdata;
    fin_err     = slverr;
`ifdef APB_ARB_TIMEOUT_EN
    tcnt_nxt    = tcnt;
`endif

    unique case (state)
      S_IDLE: begin
        if (grant_found) begin
          owner_nxt   = grant_idx;
          paddr_nxt   = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          pwrite_nxt  = req_write[grant_idx];
          // Reads never expose stale write data or strobes on the bus.
          if (req_write[grant_idx]) begin
            pwdata_nxt = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            pstrb_nxt  = req_strb[grant_idx*STRB_W +: STRB_W];
          end else begin
            pwdata_nxt = '0;
            pstrb_nxt  = '0;
          end
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = S_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        tcnt_nxt    = '0;
`endif
      end

      S_ACCESS: begin
        if (pready) begin
          fin = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
          // Silent slave: finish as an error with no data.
          fin       = 1'b1;
          fin_rdata = '0;
          fin_err   = 1'b1;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
`endif
        end

        if (fin) begin
          rdata_nxt       = fin_rdata;
          err_nxt         = fin_err;
          done_nxt[owner] = 1'b1;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rr_nxt          = (int'(owner) == int'(NREQ) - 1) ? '0 : owner + 1'b1;
          state_nxt       = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  // NOTE: reset is synchronous; it is only observed on a rising clk edge and
  // aborts any transfer in flight without producing a done pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (prst) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      pstrb   <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      done    <= '0;
      rdata   <= '0;
      err     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt    <= '0;
`endif
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_nxt;
      owner   <= owner_nxt;
      paddr   <= paddr_nxt;
      pwrite  <= pwrite_nxt;
      pwdata  <= pwdata_nxt;
      pstrb   <= pstrb_nxt;
      psel    <= psel_nxt;
      penable <= penable_nxt;
      done    <= done_nxt;
      rdata   <= rdata_nxt;
      err     <= err_nxt;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt    <= tcnt_nxt;
`endif
    end
  end

endmodule
